// File: rtl/klotski_pkg.sv
// Shared types and palette tables for the klotski tile painter.
// Level encoding per label is {R[1:0], G[1:0], B}.
package klotski_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHOW  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [7:0] LVL_LO  = 8'h20;
  localparam logic [7:0] LVL_MID = 8'h90;
  localparam logic [7:0] LVL_HI  = 8'hF0;
  localparam logic [7:0] B_LO    = 8'h20;
  localparam logic [7:0] B_HI    = 8'hF0;

  // Label 0 is the empty slot and is painted black regardless of this entry.
  localparam logic [4:0] LABEL_LVL [16] = '{
    5'b00_00_0, 5'b10_10_1, 5'b10_10_0, 5'b10_01_0,
    5'b10_00_1, 5'b10_00_0, 5'b01_10_0, 5'b01_01_0,
    5'b01_00_1, 5'b01_00_0, 5'b00_10_1, 5'b00_10_0,
    5'b00_01_1, 5'b00_01_0, 5'b00_00_1, 5'b00_00_0
  };

  // Cell 0 sits in the top nibble, so the nibble offset is (15-idx)*4 = {~idx,2'b00}.
  function automatic logic [3:0] cell_label(input logic [63:0] board, input logic [3:0] idx);
    logic [5:0] lo;
    lo = {~idx, 2'b00};
    return board[lo +: 4];
  endfunction

endpackage

// File: rtl/klotski_tile_painter_label_palette.sv
// Combinational label -> 24-bit RGB palette lookup.
module label_palette
  import klotski_pkg::*;
(
  input  logic [3:0]  label_i,
  output logic [23:0] rgb_o
);

  function automatic logic [7:0] rg_byte(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return LVL_LO;
      2'd1:    return LVL_MID;
      2'd2:    return LVL_HI;
      default: return LVL_LO;
    endcase
  endfunction

  logic [4:0] lvl_s;

  // Map the label's level triple onto byte values.
  always_comb begin
    lvl_s = LABEL_LVL[label_i];
    rgb_o = 24'h000000;
    if (label_i == 4'd0) begin
      rgb_o = 24'h000000;
    end else begin
      rgb_o = {rg_byte(lvl_s[4:3]), rg_byte(lvl_s[2:1]), (lvl_s[0] ? B_HI : B_LO)};
    end
  end

endmodule

// File: rtl/klotski_tile_painter.sv
// Latches a 4x4 label board, checks it is a permutation of 0..15, then paints VGA pixels from it.
// Optional macro KLOTSKI_GRID_LINES_EN draws white grid lines on tile boundaries.
module klotski_tile_painter
  import klotski_pkg::*;
#(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int TILE_W = 160,
  parameter int TILE_H = 120
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [63:0] i_order,
  output logic        o_busy,
  output logic        o_board_ok,
  output logic        o_error,
  input  logic        i_req,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  output logic [23:0] o_rgb,
  output logic        o_rgb_valid
);

  localparam logic [9:0] HR_C = 10'(H_RES);
  localparam logic [9:0] VR_C = 10'(V_RES);
  localparam logic [9:0] TW1  = 10'(TILE_W);
  localparam logic [9:0] TW2  = 10'(2 * TILE_W);
  localparam logic [9:0] TW3  = 10'(3 * TILE_W);
  localparam logic [9:0] TW4  = 10'(4 * TILE_W);
  localparam logic [9:0] TH1  = 10'(TILE_H);
  localparam logic [9:0] TH2  = 10'(2 * TILE_H);
  localparam logic [9:0] TH3  = 10'(3 * TILE_H);
  localparam logic [9:0] TH4  = 10'(4 * TILE_H);

  state_t      state_q;
  logic [63:0] shadow_q, disp_q;
  logic [15:0] seen_q;
  logic [3:0]  cnt_q;
  logic        dup_q, fin_q, has_q;
  logic        busy_q, ok_q, err_q;
  logic [3:0]  chk_lbl_s;
  logic        seen_hit_s;

  assign chk_lbl_s  = cell_label(shadow_q, cnt_q);
  assign seen_hit_s = seen_q[chk_lbl_s];

  // Board FSM: one cell per cycle, then a final edge to publish the verdict.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      shadow_q <= 64'd0;
      disp_q   <= 64'd0;
      seen_q   <= 16'd0;
      cnt_q    <= 4'd0;
      dup_q    <= 1'b0;
      fin_q    <= 1'b0;
      has_q    <= 1'b0;
      busy_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (i_start) begin
      state_q  <= S_CHECK;
      shadow_q <= i_order;
      seen_q   <= 16'd0;
      cnt_q    <= 4'd0;
      dup_q    <= 1'b0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b1;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_CHECK: begin
          if (!fin_q) begin
            seen_q[chk_lbl_s] <= 1'b1;
            dup_q             <= dup_q | seen_hit_s;
            cnt_q             <= cnt_q + 4'd1;
            fin_q             <= (cnt_q == 4'd15);
          end else begin
            fin_q  <= 1'b0;
            busy_q <= 1'b0;
            if (dup_q) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_SHOW;
              disp_q  <= shadow_q;
              has_q   <= 1'b1;
              ok_q    <= 1'b1;
            end
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  logic [2:0] col_d, row_d;
  logic       inr_d, grid_d;
  logic       s1_valid_q, s1_inr_q, s1_grid_q;
  logic [1:0] s1_col_q, s1_row_q;

  // Stage-1 decode: compare ladders stand in for the divide by tile size.
  always_comb begin
    col_d = 3'd4;
    row_d = 3'd4;
    if (i_x < TW1)      col_d = 3'd0;
    else if (i_x < TW2) col_d = 3'd1;
    else if (i_x < TW3) col_d = 3'd2;
    else if (i_x < TW4) col_d = 3'd3;
    else                col_d = 3'd4;
    if (i_y < TH1)      row_d = 3'd0;
    else if (i_y < TH2) row_d = 3'd1;
    else if (i_y < TH3) row_d = 3'd2;
    else if (i_y < TH4) row_d = 3'd3;
    else                row_d = 3'd4;
    inr_d = (i_x < HR_C) && (i_y < VR_C) && !col_d[2] && !row_d[2];
`ifdef KLOTSKI_GRID_LINES_EN
    grid_d = (i_x == 10'd0) || (i_x == TW1) || (i_x == TW2) || (i_x == TW3) ||
             (i_y == 10'd0) || (i_y == TH1) || (i_y == TH2) || (i_y == TH3);
`else
    grid_d = 1'b0;
`endif
  end

  logic [3:0]  pix_lbl_s;
  logic [23:0] pal_rgb_s, rgb_d;
  logic [23:0] rgb_q;
  logic        rgb_valid_q;

  assign pix_lbl_s = cell_label(disp_q, {s1_row_q, s1_col_q});

  label_palette u_palette (
    .label_i (pix_lbl_s),
    .rgb_o   (pal_rgb_s)
  );

  // Stage-2 colour select.
  always_comb begin
    rgb_d = 24'h000000;
    if (!s1_inr_q) begin
      rgb_d = 24'h000000;
    end else if (s1_grid_q) begin
      rgb_d = 24'hFFFFFF;
    end else if (!has_q) begin
      rgb_d = 24'h000000;
    end else begin
      rgb_d = pal_rgb_s;
    end
  end

  // Two-stage lookup pipeline registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_inr_q    <= 1'b0;
      s1_grid_q   <= 1'b0;
      s1_col_q    <= 2'd0;
      s1_row_q    <= 2'd0;
      rgb_q       <= 24'h000000;
      rgb_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= i_req;
      s1_inr_q    <= inr_d;
      s1_grid_q   <= grid_d;
      s1_col_q    <= col_d[1:0];
      s1_row_q    <= row_d[1:0];
      rgb_q       <= rgb_d;
      rgb_valid_q <= s1_valid_q;
    end
  end

  assign o_busy      = busy_q;
  assign o_board_ok  = ok_q;
  assign o_error     = err_q;
  assign o_rgb       = rgb_q;
  assign o_rgb_valid = rgb_valid_q;

endmodule
